rb_bus_arbiter: RTL and testbench
=================================

// Module: rb_bus_arbiter
// PURPOSE
//  Shares the single register-bank port (rb_toi2s address/wdata/write_en/rdata) between the
//  I2C slave (m0, never stalled) and one internal requester (m1, e.g. an amp sequencer).
//  m0 always has priority. m1 gets single-beat read/write slots once the I2C side has been
//  quiet for HOLDOFF cycles. Sits between i2c_if and rb_toi2s in toi2s_tt_top.
// PARAMETERS
//  AW       8  register address width
//  DW       8  register data width
//  HOLDOFF  4  idle cycles of m0 required before m1 may be granted (>=1)
//  WAIT_W   8  width of saturating m1 wait/retry statistics counters
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous reset, active-high
//  m0_reg_en      in   1   i2c_if transaction active (address phase onward)
//  m0_write_en    in   1   i2c_if write strobe, 1 cycle
//  m0_address     in   AW  i2c_if register address
//  m0_wdata       in   DW  i2c_if write data
//  m0_rdata       out  DW  read data to i2c_if (combinational pass of rb_rdata)
//  m1_req         in   1   internal request, held until m1_done
//  m1_we          in   1   1=write, 0=read; stable while m1_req
//  m1_address     in   AW  internal address; stable while m1_req
//  m1_wdata       in   DW  internal write data; stable while m1_req
//  m1_gnt         out  1   m1 owns rb port this cycle
//  m1_done        out  1   1-cycle completion pulse
//  m1_rdata       out  DW  registered read data, valid with m1_done, held until next done
//  rb_address     out  AW  to rb_toi2s address
//  rb_wdata       out  DW  to rb_toi2s data_write_in
//  rb_write_en    out  1   to rb_toi2s write_en
//  rb_rdata       in   DW  from rb_toi2s data_read_out (combinational on rb_address)
//  m1_wait_cnt    out  WAIT_W  saturating count of cycles m1_req waited (cleared at done)
//  m1_retry_cnt   out  WAIT_W  saturating count of cancelled m1 slots (cleared at reset only)
// BEHAVIOUR
//  - Reset: state IDLE, holdoff_cnt=HOLDOFF, m1_gnt=0, m1_done=0, m1_rdata=0,
//    m1_wait_cnt=0, m1_retry_cnt=0. rb_write_en follows m0_write_en, even during reset.
//  - m0_active = m0_reg_en | m0_write_en.
//  - holdoff_cnt: reload to HOLDOFF on any cycle with m0_active; else decrement to 0.
//  - FSM states:
//    IDLE: m1_req & !m0_active & holdoff_cnt==0 -> GRANT; else stay.
//    GRANT: m1_gnt=1.
//      If m0_active -> cancel. No rb write. m1_retry_cnt++. Go to IDLE.
//      Else commit: rb_* driven from m1, rb_write_en=m1_we, m1_rdata<=rb_rdata (if !m1_we).
//        Go to DONE.
//    DONE: m1_done=1 -> IDLE. holdoff_cnt is not reloaded by m1 activity.
//  - Port mux: m1 drives rb_address/rb_wdata only in GRANT with !m0_active. Otherwise m0 does.
//    rb_write_en = m0_write_en whenever m0 drives; never both.
//  - Latency: m1 request into quiet bus with holdoff_cnt==0 gives gnt at t+1 and done at t+2.
//    Back-to-back m1 accesses every 3 cycles.
//  - m0 path has zero added latency. m0_rdata = rb_rdata at all times.
//  - m1_req dropped in IDLE withdraws the request. Dropping it in GRANT/DONE is illegal
//    (assertion); the transaction completes.
//  - m1_wait_cnt increments each cycle m1_req=1 in IDLE, saturates at all-ones,
//    and clears on m1_done.
//  - m1_retry_cnt saturates at all-ones.
//  - Simultaneous m0_write_en and m1 commit are impossible by construction (cancel rule).
// STRUCTURE
//  - toi2s_pkg: add typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_DONE} rb_arb_state_t
//    and typedef struct packed {we, address, wdata} rb_m1_req_t.
//  - Single module, no sub-modules. The holdoff counter and stats counters are inline.
//  - Top: insert between i2c_inst and rb_toi2s_inst. Drive reset from !resetb.
// TESTING
//  1 Reset: assert reset 3 cycles with m1_req=1 -> m1_gnt=0, m1_done=0, both counters 0.
//  2 Quiet bus, HOLDOFF expired: m1 write addr 0x02 data 0xA5 -> gnt t+1, rb_write_en=1
//    addr 0x02, done t+2. m0 read of 0x02 then returns 0xA5.
//  3 m0 reg_en high 10 cycles with m1_req pending -> no gnt until 4 cycles after reg_en
//    falls. m1_wait_cnt counts >=14 then clears at done.
//  4 m0_write_en (addr 0x01, 0x3C) in the m1 GRANT cycle -> m1 cancelled, reg 0x01=0x3C,
//    m1_retry_cnt=1, m1 retried later and completes.
//  5 m1 read of 0x00 after m0 wrote 0x5A -> m1_rdata=0x5A with m1_done; held through
//    a following m0 transaction.
//  6 Hold m1_req for 300 cycles under m0_reg_en=1 -> m1_wait_cnt saturates at 0xFF,
//    no wrap.

Source files
------------

// File: rtl/rb_bus_arbiter_pkg.sv
// Shared types for the register-bank port arbiter.
package rb_bus_arbiter_pkg;

   // Default register-bank geometry of the integrated design
   localparam int RB_AW = 8;
   localparam int RB_DW = 8;

   // Arbiter slot sequencing: wait for a quiet bus, own the port one cycle, report completion
   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_GRANT,
      ARB_DONE
   } rb_arb_state_t;

   // One internal (m1) access as seen at the default register-bank geometry
   typedef struct packed {
      logic             we;
      logic [RB_AW-1:0] address;
      logic [RB_DW-1:0] wdata;
   } rb_m1_req_t;

endpackage

// File: rtl/rb_bus_arbiter.sv
// Shares the single register-bank port between the I2C slave (m0, never
// stalled, absolute priority) and one internal requester (m1). m1 receives
// single-beat slots only after m0 has been idle for HOLDOFF cycles; an m0
// access landing on the grant cycle cancels the slot and m1 retries later.
module rb_bus_arbiter
   import rb_bus_arbiter_pkg::*;
#(
   parameter int AW      = 8,
   parameter int DW      = 8,
   parameter int HOLDOFF = 4,
   parameter int WAIT_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_reg_en,
   input  logic              m0_write_en,
   input  logic [AW-1:0]     m0_address,
   input  logic [DW-1:0]     m0_wdata,
   output logic [DW-1:0]     m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [AW-1:0]     m1_address,
   input  logic [DW-1:0]     m1_wdata,
   output logic              m1_gnt,
   output logic              m1_done,
   output logic [DW-1:0]     m1_rdata,
   output logic [AW-1:0]     rb_address,
   output logic [DW-1:0]     rb_wdata,
   output logic              rb_write_en,
   input  logic [DW-1:0]     rb_rdata,
   output logic [WAIT_W-1:0] m1_wait_cnt,
   output logic [WAIT_W-1:0] m1_retry_cnt
);

   localparam int                HW        = $clog2(HOLDOFF + 1);
   localparam logic [HW-1:0]     HOLDOFF_V = HW'(HOLDOFF);
   localparam logic [WAIT_W-1:0] SAT       = '1;

   rb_arb_state_t     state_q, state_d;
   logic [HW-1:0]     holdoff_q, holdoff_d;
   logic [DW-1:0]     m1_rdata_q, m1_rdata_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [WAIT_W-1:0] retry_q, retry_d;
   logic              m0_active;
   logic              m1_commit;

   assign m0_active = m0_reg_en | m0_write_en;

   // m1 only touches the bank in a grant cycle m0 left alone; reset keeps m0 in charge
   assign m1_commit = (state_q == ARB_GRANT) & ~m0_active & ~reset;

   // State and statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ARB_IDLE;
         holdoff_q  <= HOLDOFF_V;
         m1_rdata_q <= '0;
         wait_q     <= '0;
         retry_q    <= '0;
      end else begin
         state_q    <= state_d;
         holdoff_q  <= holdoff_d;
         m1_rdata_q <= m1_rdata_d;
         wait_q     <= wait_d;
         retry_q    <= retry_d;
      end
   end

   // Next-state: holdoff timer, slot sequencing, read capture and saturating statistics
   always_comb begin
      state_d    = state_q;
      m1_rdata_d = m1_rdata_q;
      wait_d     = wait_q;
      retry_d    = retry_q;
      // Only m0 activity restarts the quiet window; m1's own slots never do
      if (m0_active) begin
         holdoff_d = HOLDOFF_V;
      end else if (holdoff_q != '0) begin
         holdoff_d = holdoff_q - 1'b1;
      end else begin
         holdoff_d = holdoff_q;
      end
      case (state_q)
         ARB_IDLE: begin
            if (m1_req && (wait_q != SAT)) begin
               wait_d = wait_q + 1'b1;
            end
            if (m1_req && !m0_active && (holdoff_q == '0)) begin
               state_d = ARB_GRANT;
            end
         end
         ARB_GRANT: begin
            if (m0_active) begin
               // m0 arrived on top of the slot: drop it, m1 waits for another quiet window
               if (retry_q != SAT) begin
                  retry_d = retry_q + 1'b1;
               end
               state_d = ARB_IDLE;
            end else begin
               if (!m1_we) begin
                  m1_rdata_d = rb_rdata;
               end
               state_d = ARB_DONE;
            end
         end
         ARB_DONE: begin
            wait_d  = '0;
            state_d = ARB_IDLE;
         end
         default: begin
            state_d = ARB_IDLE;
         end
      endcase
   end

   // Port mux: m0 owns the bank unless m1 is committing this cycle
   always_comb begin
      rb_address  = m0_address;
      rb_wdata    = m0_wdata;
      rb_write_en = m0_write_en;
      if (m1_commit) begin
         rb_address  = m1_address;
         rb_wdata    = m1_wdata;
         rb_write_en = m1_we;
      end
   end

   assign m0_rdata     = rb_rdata;
   assign m1_gnt       = (state_q == ARB_GRANT);
   assign m1_done      = (state_q == ARB_DONE);
   assign m1_rdata     = m1_rdata_q;
   assign m1_wait_cnt  = wait_q;
   assign m1_retry_cnt = retry_q;

   // Once granted, m1 must keep requesting until its done pulse
   a_m1_req_held : assert property (@(posedge clk) disable iff (reset)
      (state_q != ARB_IDLE) |-> m1_req);

endmodule

// File: tb/tb_rb_bus_arbiter.sv
// Testbench for rb_bus_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle to a behavioural model.
module tb_rb_bus_arbiter;

   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int HOLDOFF = 4;
   localparam int WAIT_W  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              m0_reg_en, m0_write_en;
   logic [AW-1:0]     m0_address;
   logic [DW-1:0]     m0_wdata, m0_rdata;
   logic              m1_req, m1_we;
   logic [AW-1:0]     m1_address;
   logic [DW-1:0]     m1_wdata;
   logic              m1_gnt, m1_done;
   logic [DW-1:0]     m1_rdata;
   logic [AW-1:0]     rb_address;
   logic [DW-1:0]     rb_wdata;
   logic              rb_write_en;
   logic [DW-1:0]     rb_rdata;
   logic [WAIT_W-1:0] m1_wait_cnt, m1_retry_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   rb_bus_arbiter #(.AW(AW), .DW(DW), .HOLDOFF(HOLDOFF), .WAIT_W(WAIT_W)) dut (
      .clk(clk), .reset(reset),
      .m0_reg_en(m0_reg_en), .m0_write_en(m0_write_en), .m0_address(m0_address),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_address(m1_address), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
      .rb_address(rb_address), .rb_wdata(rb_wdata), .rb_write_en(rb_write_en),
      .rb_rdata(rb_rdata), .m1_wait_cnt(m1_wait_cnt), .m1_retry_cnt(m1_retry_cnt)
   );

   always #5 clk = ~clk;

   // Register bank stand-in: combinational read, write on the clock edge
   logic [DW-1:0] regbank [256];
   assign rb_rdata = regbank[rb_address];
   always @(posedge clk) if (rb_write_en) regbank[rb_address] <= rb_wdata;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // quiet  : consecutive cycles without m0 activity
   // phase  : 0 = m1 waiting/none, 1 = slot offered this cycle, 2 = completion cycle
   logic [DW-1:0] exp_mem [256];
   int quiet, phase, mdl_rdata, mdl_wait, mdl_retry;
   bit chk_en = 1'b0;

   always @(posedge clk) begin
      bit act;
      act = m0_reg_en | m0_write_en;
      if (reset) begin
         quiet = 0; phase = 0; mdl_rdata = 0; mdl_wait = 0; mdl_retry = 0;
      end else begin
         case (phase)
            0: begin
               if (m1_req) mdl_wait = (mdl_wait < 255) ? mdl_wait + 1 : 255;
               if (m1_req && !act && quiet >= HOLDOFF) phase = 1;
            end
            1: begin
               if (act) begin
                  mdl_retry = (mdl_retry < 255) ? mdl_retry + 1 : 255;
                  phase = 0;
               end else begin
                  if (m1_we) exp_mem[m1_address] = m1_wdata;
                  else mdl_rdata = exp_mem[m1_address];
                  phase = 2;
               end
            end
            default: begin
               mdl_wait = 0;
               phase = 0;
            end
         endcase
         quiet = act ? 0 : ((quiet < 1000) ? quiet + 1 : quiet);
      end
      if (m0_write_en) exp_mem[m0_address] = m0_wdata;
      chk_en = 1'b1;
   end

   // Single compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         bit            m1_owns;
         logic [AW-1:0] e_addr;
         logic [DW-1:0] e_wd;
         bit            e_we;
         m1_owns = !reset && phase == 1 && !(m0_reg_en | m0_write_en);
         e_addr  = m1_owns ? m1_address : m0_address;
         e_wd    = m1_owns ? m1_wdata : m0_wdata;
         e_we    = m1_owns ? m1_we : m0_write_en;
         check("m1_gnt", m1_gnt, (phase == 1));
         check("m1_done", m1_done, (phase == 2));
         check("m1_rdata", m1_rdata, mdl_rdata);
         check("m1_wait_cnt", m1_wait_cnt, mdl_wait);
         check("m1_retry_cnt", m1_retry_cnt, mdl_retry);
         check("rb_address", rb_address, e_addr);
         check("rb_wdata", rb_wdata, e_wd);
         check("rb_write_en", rb_write_en, e_we);
         check("m0_rdata", m0_rdata, exp_mem[e_addr]);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Advance until the completion cycle is current (bounded)
   task automatic wait_done(input int max_cyc, input string name);
      int n = 0;
      while (!m1_done && n < max_cyc) begin
         step(1);
         n++;
      end
      if (!m1_done) check(name, 0, 1);
   endtask

   initial begin
      int g;
      logic [7:0] w_at_g;
      int burst;
      bit last_done;

      for (int i = 0; i < 256; i++) begin
         regbank[i] = '0;
         exp_mem[i] = '0;
      end
      reset = 1'b1;
      m0_reg_en = 0; m0_write_en = 0; m0_address = 0; m0_wdata = 0;
      m1_req = 1'b1; m1_we = 1'b1; m1_address = 8'h02; m1_wdata = 8'hA5;

      // 1: reset held 3 cycles with m1_req asserted
      for (int i = 0; i < 3; i++) begin
         step(1);
         check("t1_gnt", m1_gnt, 0);
         check("t1_done", m1_done, 0);
         check("t1_wait", m1_wait_cnt, 0);
         check("t1_retry", m1_retry_cnt, 0);
      end
      reset = 1'b0;
      m1_req = 1'b0;
      step(6);

      // 2: m1 write into a quiet bus
      m1_we = 1'b1; m1_address = 8'h02; m1_wdata = 8'hA5; m1_req = 1'b1;
      #1 check("t2_gnt_t0", m1_gnt, 0);
      step(1);
      check("t2_gnt_t1", m1_gnt, 1);
      check("t2_rb_we", rb_write_en, 1);
      check("t2_rb_addr", rb_address, 8'h02);
      check("t2_rb_wdata", rb_wdata, 8'hA5);
      step(1);
      check("t2_done_t2", m1_done, 1);
      step(1);
      m1_req = 1'b0;
      m0_reg_en = 1'b1; m0_address = 8'h02;
      #1 check("t2_m0_read", m0_rdata, 8'hA5);
      step(1);
      m0_reg_en = 1'b0;
      step(6);

      // 3: m0 busy 10 cycles while m1 waits
      g = -1; w_at_g = '0;
      m1_we = 1'b1; m1_address = 8'h10; m1_wdata = 8'h33; m1_req = 1'b1;
      m0_reg_en = 1'b1; m0_address = 8'h10;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) m0_reg_en = 1'b0;
         #1;
         if (m1_gnt && g < 0) begin
            g = i;
            w_at_g = m1_wait_cnt;
         end
         if (m1_done) begin
            step(1);
            break;
         end
         step(1);
      end
      m1_req = 1'b0;
      check("t3_first_gnt_cycle", g, 15);
      check("t3_wait_ge14", (w_at_g >= 8'd14), 1);
      check("t3_wait_cleared", m1_wait_cnt, 0);
      step(6);

      // 4: m0 write lands on the grant cycle -> cancel and retry
      m1_we = 1'b1; m1_address = 8'h05; m1_wdata = 8'h77; m1_req = 1'b1;
      step(1);
      check("t4_gnt", m1_gnt, 1);
      m0_write_en = 1'b1; m0_address = 8'h01; m0_wdata = 8'h3C;
      #1;
      check("t4_rb_we_m0", rb_write_en, 1);
      check("t4_rb_addr_m0", rb_address, 8'h01);
      check("t4_rb_wdata_m0", rb_wdata, 8'h3C);
      step(1);
      m0_write_en = 1'b0;
      check("t4_retry", m1_retry_cnt, 1);
      check("t4_gnt_dropped", m1_gnt, 0);
      wait_done(40, "t4_done_timeout");
      step(1);
      m1_req = 1'b0;
      m0_reg_en = 1'b1; m0_address = 8'h01;
      #1 check("t4_reg01", m0_rdata, 8'h3C);
      m0_address = 8'h05;
      #1 check("t4_reg05", m0_rdata, 8'h77);
      step(1);
      m0_reg_en = 1'b0;
      step(6);

      // 5: m1 read after m0 write, held through a later m0 transaction
      m0_reg_en = 1'b1; m0_write_en = 1'b1; m0_address = 8'h00; m0_wdata = 8'h5A;
      step(1);
      m0_reg_en = 1'b0; m0_write_en = 1'b0;
      m1_we = 1'b0; m1_address = 8'h00; m1_req = 1'b1;
      wait_done(40, "t5_done_timeout");
      check("t5_rdata_at_done", m1_rdata, 8'h5A);
      step(1);
      m1_req = 1'b0;
      m0_reg_en = 1'b1; m0_write_en = 1'b1; m0_address = 8'h03; m0_wdata = 8'h11;
      step(1);
      m0_write_en = 1'b0;
      step(2);
      m0_reg_en = 1'b0;
      check("t5_rdata_held", m1_rdata, 8'h5A);
      step(2);

      // 6: long wait saturates
      m1_we = 1'b0; m1_address = 8'h07; m1_req = 1'b1; m0_reg_en = 1'b1;
      step(300);
      check("t6_wait_sat", m1_wait_cnt, 8'hFF);
      m0_reg_en = 1'b0;
      wait_done(40, "t6_done_timeout");
      step(1);
      m1_req = 1'b0;
      check("t6_wait_cleared", m1_wait_cnt, 0);

      // Randomized traffic, legal m1 protocol, one mid-run reset
      burst = 0;
      last_done = 1'b0;
      for (int it = 0; it < 3000; it++) begin
         if (it == 1500) begin
            reset = 1'b1; m1_req = 1'b0; m0_reg_en = 1'b0; m0_write_en = 1'b0;
            burst = 0;
            step(2);
            reset = 1'b0;
            last_done = 1'b0;
         end
         m0_write_en = 1'b0;
         if (burst > 0) begin
            m0_reg_en = 1'b1;
            burst--;
         end else begin
            m0_reg_en = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
               burst = int'($urandom_range(1, 12));
               m0_address = 8'($urandom_range(0, 15));
            end
         end
         if ((m0_reg_en && $urandom_range(0, 5) == 0) || (m1_gnt && $urandom_range(0, 2) == 0)) begin
            m0_write_en = 1'b1;
            if (!m0_reg_en) m0_address = 8'($urandom_range(0, 15));
            m0_wdata = 8'($urandom);
         end
         if (m1_req && last_done) begin
            m1_req = 1'b0;
         end else if (m1_req && !m1_gnt && !m1_done && $urandom_range(0, 19) == 0) begin
            m1_req = 1'b0;
         end else if (!m1_req && $urandom_range(0, 2) == 0) begin
            m1_we = 1'($urandom_range(0, 1));
            m1_address = 8'($urandom_range(0, 15));
            m1_wdata = 8'($urandom);
            m1_req = 1'b1;
         end
         last_done = m1_done;
         step(1);
      end
      m1_req = 1'b0;
      m0_reg_en = 1'b0;
      m0_write_en = 1'b0;
      step(3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
